// File: rtl/cvp_pkg.sv
// Shared opcode table, occupancy states and operand-class helper for the operand stage.
package cvp_pkg;

  localparam logic [3:0] OP_VADD = 4'd0;
  localparam logic [3:0] OP_VDOT = 4'd1;
  localparam logic [3:0] OP_SMUL = 4'd2;
  localparam logic [3:0] OP_SST  = 4'd3;
  localparam logic [3:0] OP_VLD  = 4'd4;
  localparam logic [3:0] OP_VST  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SLH  = 4'd7;
  localparam logic [3:0] OP_J    = 4'd8;
  localparam logic [3:0] OP_NOP  = 4'd15;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // 1 when source n (1 or 2) of this opcode reads the vector file.
  function automatic logic is_vec_src(input logic [3:0] functype, input logic [1:0] n);
    logic r_vec;
    r_vec = 1'b0;
    case (functype)
      OP_VADD, OP_VDOT: r_vec = 1'b1;
      OP_SMUL:          r_vec = (n == 2'd1);
      default:          r_vec = 1'b0;
    endcase
    return r_vec;
  endfunction

endpackage

// File: rtl/operand_skid_buf.sv
// Generic 2-entry valid/ready buffer (main + skid register) with registered in_ready/out_valid.
module operand_skid_buf
  import cvp_pkg::*;
#(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_e         r_state;
  occ_e         w_state_nxt;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         w_accept;
  logic         w_deliver;
  logic         w_load_main_in;
  logic         w_load_main_skid;
  logic         w_load_skid;

  assign w_accept  = in_valid && r_in_ready;
  assign w_deliver = r_out_valid && out_ready;

  // Occupancy next-state and register load selects.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      OCC_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = OCC_ONE;
          w_load_main_in = 1'b1;
        end else begin
          w_state_nxt = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (w_accept && w_deliver) begin
          w_state_nxt    = OCC_ONE;
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = OCC_TWO;
          w_load_skid = 1'b1;
        end else if (w_deliver) begin
          w_state_nxt = OCC_EMPTY;
        end else begin
          w_state_nxt = OCC_ONE;
        end
      end
      OCC_TWO: begin
        if (w_deliver) begin
          w_state_nxt      = OCC_ONE;
          w_load_main_skid = 1'b1;
        end else begin
          w_state_nxt = OCC_TWO;
        end
      end
      default: w_state_nxt = OCC_EMPTY;
    endcase
  end

  // State plus handshake flags, both derived from the next occupancy so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= OCC_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != OCC_TWO);
      r_out_valid <= (w_state_nxt != OCC_EMPTY);
    end
  end

  // Data registers; the skid entry always drains into main so order is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= RST_VAL;
      r_skid <= RST_VAL;
    end else begin
      if (w_load_main_in) begin
        r_main <= in_data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end else begin
        r_main <= r_main;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end else begin
        r_skid <= r_skid;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;

endmodule

// File: rtl/operand_stage.sv
// Operand-select stage: writeback forwarding and opcode-driven op1/op2 selection,
// registered through a 2-entry skid buffer toward execute.
module operand_stage
  import cvp_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int LANE_W     = 16,
  parameter int REG_IDX_W  = 3,
  parameter int SMUL_BCAST = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  functype,
  input  logic [REG_IDX_W-1:0]        rs1_idx,
  input  logic [REG_IDX_W-1:0]        rs2_idx,
  input  logic [LANES*LANE_W-1:0]     vec_data1,
  input  logic [LANES*LANE_W-1:0]     vec_data2,
  input  logic [LANE_W-1:0]           sc_data1,
  input  logic [LANE_W-1:0]           sc_data2,
  input  logic [7:0]                  immediate,
  input  logic [5:0]                  offset,
  input  logic [11:0]                 jump_off,
  input  logic [15:0]                 pc,
  input  logic                        wb_valid,
  input  logic                        wb_is_vec,
  input  logic [REG_IDX_W-1:0]        wb_idx,
  input  logic [LANES*LANE_W-1:0]     wb_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [3:0]                  out_functype,
  output logic [LANES*LANE_W-1:0]     op1,
  output logic [LANES*LANE_W-1:0]     op2
);

  localparam int VEC_W = LANES * LANE_W;
  localparam int BUF_W = 4 + 2 * VEC_W;

  logic              w_hit1;
  logic              w_hit2;
  logic [VEC_W-1:0]  w_vec1;
  logic [VEC_W-1:0]  w_vec2;
  logic [LANE_W-1:0] w_sc1;
  logic [LANE_W-1:0] w_sc2;
  logic [LANE_W-1:0] w_off_ext;
  logic [15:0]       w_jmp_ext;
  logic [VEC_W-1:0]  w_smul_op2;
  logic [VEC_W-1:0]  w_op1;
  logic [VEC_W-1:0]  w_op2;
  logic [BUF_W-1:0]  w_out_data;

  // A hit requires the writeback file to match the class this opcode reads for that source.
  assign w_hit1 = wb_valid && (wb_idx == rs1_idx) && (wb_is_vec == is_vec_src(functype, 2'd1));
  assign w_hit2 = wb_valid && (wb_idx == rs2_idx) && (wb_is_vec == is_vec_src(functype, 2'd2));

  assign w_vec1 = w_hit1 ? wb_data : vec_data1;
  assign w_vec2 = w_hit2 ? wb_data : vec_data2;
  assign w_sc1  = w_hit1 ? wb_data[LANE_W-1:0] : sc_data1;
  assign w_sc2  = w_hit2 ? wb_data[LANE_W-1:0] : sc_data2;

  assign w_off_ext  = {{(LANE_W-6){offset[5]}}, offset};
  assign w_jmp_ext  = {{4{jump_off[11]}}, jump_off};
  assign w_smul_op2 = (SMUL_BCAST != 0) ? {LANES{w_sc2}} : VEC_W'(w_sc2);

  // Operand select by opcode; unknown codes pass through with zero operands.
  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    case (functype)
      OP_VADD, OP_VDOT: begin
        w_op1 = w_vec1;
        w_op2 = w_vec2;
      end
      OP_SMUL: begin
        w_op1 = w_vec1;
        w_op2 = w_smul_op2;
      end
      OP_VLD, OP_VST, OP_SST: begin
        w_op1 = VEC_W'(w_sc1);
        w_op2 = VEC_W'(w_off_ext);
      end
      OP_SLL, OP_SLH: begin
        w_op1 = VEC_W'(w_sc1);
        w_op2 = VEC_W'(immediate);
      end
      OP_J: begin
        w_op1 = VEC_W'(pc);
        w_op2 = VEC_W'(w_jmp_ext);
      end
      default: begin
        w_op1 = '0;
        w_op2 = '0;
      end
    endcase
  end

  operand_skid_buf #(
    .W       (BUF_W),
    .RST_VAL ({OP_NOP, {(2*VEC_W){1'b0}}})
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({functype, w_op1, w_op2}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data)
  );

  assign {out_functype, op1, op2} = w_out_data;

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: directed corner cases plus randomized traffic vs a reference model.
module tb_operand_stage;

  localparam int LANES  = 16;
  localparam int LANE_W = 16;
  localparam int RW     = 3;
  localparam int VW     = LANES * LANE_W;
  localparam int CW     = VW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    functype;
  logic [RW-1:0] rs1_idx, rs2_idx;
  logic [VW-1:0] vec_data1, vec_data2;
  logic [15:0]   sc_data1, sc_data2;
  logic [7:0]    immediate;
  logic [5:0]    offset;
  logic [11:0]   jump_off;
  logic [15:0]   pc;
  logic          wb_valid, wb_is_vec;
  logic [RW-1:0] wb_idx;
  logic [VW-1:0] wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_functype;
  logic [VW-1:0] op1, op2;

  operand_stage #(
    .LANES(LANES), .LANE_W(LANE_W), .REG_IDX_W(RW), .SMUL_BCAST(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .functype(functype), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .vec_data1(vec_data1), .vec_data2(vec_data2), .sc_data1(sc_data1), .sc_data2(sc_data2),
    .immediate(immediate), .offset(offset), .jump_off(jump_off), .pc(pc),
    .wb_valid(wb_valid), .wb_is_vec(wb_is_vec), .wb_idx(wb_idx), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_functype(out_functype),
    .op1(op1), .op2(op2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    ft;
    logic [VW-1:0] op1;
    logic [VW-1:0] op2;
  } exp_t;

  typedef struct packed {
    logic [3:0]    ft;
    logic [RW-1:0] rs1, rs2;
    logic [VW-1:0] vec1, vec2;
    logic [15:0]   sc1, sc2;
    logic [7:0]    imm;
    logic [5:0]    off;
    logic [11:0]   jo;
    logic [15:0]   pc;
    logic          wbv, wbvec;
    logic [RW-1:0] wbidx;
    logic [VW-1:0] wbd;
  } stim_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_del = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model: operands derived straight from the opcode rules with integer arithmetic.
  function automatic exp_t model(input stim_t s);
    exp_t          e;
    logic [VW-1:0] v1, v2;
    logic [15:0]   s1, s2;
    int            o;
    int            j;
    bit            hit1, hit2;
    hit1 = s.wbv && (s.wbidx == s.rs1);
    hit2 = s.wbv && (s.wbidx == s.rs2);
    v1 = (hit1 && s.wbvec)  ? s.wbd : s.vec1;
    v2 = (hit2 && s.wbvec)  ? s.wbd : s.vec2;
    s1 = (hit1 && !s.wbvec) ? s.wbd[15:0] : s.sc1;
    s2 = (hit2 && !s.wbvec) ? s.wbd[15:0] : s.sc2;
    o = int'(s.off);
    if (o >= 32) o = o - 64;
    j = int'(s.jo);
    if (j >= 2048) j = j - 4096;
    e.ft  = s.ft;
    e.op1 = '0;
    e.op2 = '0;
    case (s.ft)
      4'd0, 4'd1: begin e.op1 = v1; e.op2 = v2; end
      4'd2: begin
        e.op1 = v1;
        for (int l = 0; l < LANES; l++) e.op2[l*16 +: 16] = s2;
      end
      4'd3, 4'd4, 4'd5: begin e.op1[15:0] = s1; e.op2[15:0] = o[15:0]; end
      4'd6, 4'd7: begin e.op1[15:0] = s1; e.op2[7:0] = s.imm; end
      4'd8: begin e.op1[15:0] = s.pc; e.op2[15:0] = j[15:0]; end
      default: begin e.op1 = '0; e.op2 = '0; end
    endcase
    return e;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < VW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.ft    = 4'($urandom_range(0, 15));
    s.rs1   = RW'($urandom_range(0, 7));
    s.rs2   = RW'($urandom_range(0, 7));
    s.vec1  = rand_vec();
    s.vec2  = rand_vec();
    s.sc1   = 16'($urandom());
    s.sc2   = 16'($urandom());
    s.imm   = 8'($urandom());
    s.off   = 6'($urandom());
    s.jo    = 12'($urandom());
    s.pc    = 16'($urandom());
    s.wbv   = 1'($urandom_range(0, 1));
    s.wbvec = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 2))
      0: s.wbidx = s.rs1;
      1: s.wbidx = s.rs2;
      default: s.wbidx = RW'($urandom_range(0, 7));
    endcase
    s.wbd = rand_vec();
    return s;
  endfunction

  task automatic apply(input stim_t s);
    functype  = s.ft;    rs1_idx   = s.rs1;   rs2_idx  = s.rs2;
    vec_data1 = s.vec1;  vec_data2 = s.vec2;
    sc_data1  = s.sc1;   sc_data2  = s.sc2;
    immediate = s.imm;   offset    = s.off;   jump_off = s.jo;  pc = s.pc;
    wb_valid  = s.wbv;   wb_is_vec = s.wbvec; wb_idx   = s.wbidx; wb_data = s.wbd;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(input stim_t s, input exp_t e);
    int w;
    apply(s);
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stuck at 0 for op %0d", s.ft);
    end else begin
      exp_q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare each delivered op against the queue, and check outputs hold while stalled.
  initial begin
    exp_t e;
    exp_t held;
    bit   stall_pending;
    stall_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (stall_pending) begin
          check("stall_op1", op1, held.op1);
          check("stall_ft", CW'(out_functype), CW'(held.ft));
        end
        if (out_ready) begin
          stall_pending = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: ft=%0d with empty scoreboard", out_functype);
          end else begin
            e = exp_q.pop_front();
            n_del++;
            check("out_functype", CW'(out_functype), CW'(e.ft));
            check("op1", op1, e.op1);
            check("op2", op2, e.op2);
          end
        end else begin
          held = {out_functype, op1, op2};
          stall_pending = 1'b1;
        end
      end else begin
        stall_pending = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    stim_t         s;
    stim_t         c;
    exp_t          e;
    logic [VW-1:0] rep;
    int            c0;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    apply('0);
    #12;
    check("rst_out_valid", CW'(out_valid), CW'(1'b0));
    check("rst_in_ready", CW'(in_ready), CW'(1'b1));
    check("rst_op1", op1, '0);
    check("rst_op2", op2, '0);
    check("rst_functype", CW'(out_functype), CW'(4'hF));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases with hand-derived expectations.
    out_ready = 1'b1;
    s = '0; s.ft = 4'd4; s.sc1 = 16'h1000; s.off = 6'h3E;
    e.ft = 4'd4; e.op1 = VW'(16'h1000); e.op2 = VW'(16'hFFFE);
    send(s, e);
    check("latency_out_valid", CW'(out_valid), CW'(1'b1));

    s = '0; s.ft = 4'd8; s.pc = 16'h0040; s.jo = 12'h800;
    e.ft = 4'd8; e.op1 = VW'(16'h0040); e.op2 = VW'(16'hF800);
    send(s, e);

    s = '0; s.ft = 4'd2; s.vec1 = rand_vec(); s.sc2 = 16'h0003;
    rep = {LANES{16'h0003}};
    e.ft = 4'd2; e.op1 = s.vec1; e.op2 = rep;
    send(s, e);

    s = '0; s.ft = 4'd3; s.rs1 = 3'd2; s.sc1 = 16'h1234; s.off = 6'h05;
    s.wbv = 1'b1; s.wbvec = 1'b0; s.wbidx = 3'd2; s.wbd = ~(VW'(0)); s.wbd[15:0] = 16'h0055;
    e.ft = 4'd3; e.op1 = VW'(16'h0055); e.op2 = VW'(16'h0005);
    send(s, e);
    s.wbvec = 1'b1;
    e.op1 = VW'(16'h1234);
    send(s, e);

    s = '0; s.ft = 4'd0; s.rs1 = 3'd2; s.rs2 = 3'd3; s.vec1 = rand_vec(); s.vec2 = rand_vec();
    s.wbv = 1'b1; s.wbvec = 1'b1; s.wbidx = 3'd3; s.wbd = rand_vec();
    e.ft = 4'd0; e.op1 = s.vec1; e.op2 = s.wbd;
    send(s, e);

    s = '0; s.ft = 4'd6; s.sc1 = 16'hBEEF; s.imm = 8'hA5;
    e.ft = 4'd6; e.op1 = VW'(16'hBEEF); e.op2 = VW'(8'hA5);
    send(s, e);

    s = rand_stim(); s.ft = 4'd15;
    e.ft = 4'd15; e.op1 = '0; e.op2 = '0;
    send(s, e);
    s = rand_stim(); s.ft = 4'd11;
    e.ft = 4'd11;
    send(s, e);
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: fill both entries, hold C, then release.
    out_ready = 1'b0;
    s = rand_stim(); send(s, model(s));
    s = rand_stim(); send(s, model(s));
    check("in_ready_full", CW'(in_ready), CW'(1'b0));
    c = rand_stim();
    apply(c);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("in_ready_held", CW'(in_ready), CW'(1'b0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(c, model(c));
    repeat (4) @(posedge clk);
    #1;
    check("bp_queue_empty", CW'(exp_q.size()), CW'(0));
    check("bp_delivered", CW'(n_del), CW'(n_acc));

    // Reset while both entries are occupied.
    out_ready = 1'b0;
    s = rand_stim(); send(s, model(s));
    s = rand_stim(); send(s, model(s));
    check("pre_rst_full", CW'(in_ready), CW'(1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", CW'(out_valid), CW'(1'b0));
    check("midrst_in_ready", CW'(in_ready), CW'(1'b1));
    check("midrst_op1", op1, '0);
    n_acc = n_acc - exp_q.size();
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full throughput: one op per cycle with execute always ready.
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      s = rand_stim();
      send(s, model(s));
    end
    check("throughput_cycles", CW'(cyc - c0), CW'(100));
    repeat (3) @(posedge clk);
    #1;

    // Random execute back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s = rand_stim();
      send(s, model(s));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", CW'(exp_q.size()), CW'(0));
    check("final_delivered", CW'(n_del), CW'(n_acc));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
